// File: rtl/xilly_lane_pipe.sv
// Lane-parallel passthrough / running-sum core between Xillybus write and read FIFO ports.
// Optional macro XILLY_LANE_SAT_EN: in MODE 1, lane sums saturate instead of wrapping.
module xilly_lane_pipe #(
  parameter int LANES  = 2,
  parameter int LANE_W = 16,
  parameter int DEPTH  = 512,
  parameter int MODE   = 1
) (
  input  logic                          bus_clk,
  input  logic                          quiesce,
  input  logic [LANES*LANE_W-1:0]       user_w_write_data,
  input  logic                          user_w_write_wren,
  input  logic                          user_w_write_open,
  output logic                          user_w_write_full,
  output logic [LANES*LANE_W-1:0]       user_r_read_data,
  input  logic                          user_r_read_rden,
  input  logic                          user_r_read_open,
  output logic                          user_r_read_empty,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int W  = LANES * LANE_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_s1_valid;
  logic [W-1:0]  r_s1_data;
  logic [W-1:0]  r_acc;
  logic          r_overflow;
  logic [W-1:0]  r_rdata;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic [W-1:0]  w_sum;
  logic [AW+1:0] w_reserved;

  // The stage-1 word already owns a slot, so it counts toward full.
  assign w_reserved = {1'b0, r_level} + {{(AW+1){1'b0}}, r_s1_valid};
  assign w_full     = (w_reserved >= DEPTH_V);
  assign w_empty    = (r_level == '0);
  assign w_accept   = user_w_write_wren && user_w_write_open && !w_full;
  assign w_pop      = user_r_read_rden && user_r_read_open && !w_empty;
  assign w_push     = r_s1_valid;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] w_in;
      assign w_in = user_w_write_data[gi*LANE_W +: LANE_W];
      if (MODE == 0) begin : g_pass
        assign w_sum[gi*LANE_W +: LANE_W] = w_in;
      end else begin : g_acc
        logic [LANE_W-1:0] w_acc;
        assign w_acc = r_acc[gi*LANE_W +: LANE_W];
`ifdef XILLY_LANE_SAT_EN
        logic [LANE_W:0] w_wide;
        assign w_wide = {1'b0, w_acc} + {1'b0, w_in};
        assign w_sum[gi*LANE_W +: LANE_W] = w_wide[LANE_W] ? {LANE_W{1'b1}} : w_wide[LANE_W-1:0];
`else
        assign w_sum[gi*LANE_W +: LANE_W] = w_acc + w_in;
`endif
      end
    end
  endgenerate

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_sum;
      end
      // A closed write stream restarts every lane sum; accept implies open, so no conflict.
      if (!user_w_write_open) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum;
      end
      if (user_w_write_wren && user_w_write_open && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_s1_data;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign user_w_write_full = w_full;
  assign user_r_read_empty = w_empty;
  assign user_r_read_data  = r_rdata;
  assign overflow          = r_overflow;
  assign level             = r_level;

endmodule

// File: tb/tb_xilly_lane_pipe.sv
// Bench for xilly_lane_pipe: MODE 0 and MODE 1 instances share stimulus; each is checked
// every cycle against a queue-based model, plus directed literal expectations.
module tb_xilly_lane_pipe;

  logic        clk = 1'b0;
  logic        quiesce = 1'b1;
  logic [31:0] wdata = '0;
  logic        wren = 1'b0;
  logic        wopen = 1'b1;
  logic        rden = 1'b0;
  logic        ropen = 1'b1;

  logic [1:0]       full_w;
  logic [1:0]       empty_w;
  logic [1:0]       ovf_w;
  logic [1:0][31:0] rdat_w;
  logic [1:0][4:0]  lvl_w;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s mode=%0d got=%h want=%h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  for (genvar gm = 0; gm < 2; gm++) begin : g_m
    xilly_lane_pipe #(.LANES(2), .LANE_W(16), .DEPTH(16), .MODE(gm)) u_dut (
      .bus_clk           (clk),
      .quiesce           (quiesce),
      .user_w_write_data (wdata),
      .user_w_write_wren (wren),
      .user_w_write_open (wopen),
      .user_w_write_full (full_w[gm]),
      .user_r_read_data  (rdat_w[gm]),
      .user_r_read_rden  (rden),
      .user_r_read_open  (ropen),
      .user_r_read_empty (empty_w[gm]),
      .overflow          (ovf_w[gm]),
      .level             (lvl_w[gm])
    );

    // Model: a word in flight plus a queue of stored words.
    logic [31:0] q[$];
    bit          pv;
    logic [31:0] pd;
    int          acc[2];
    bit          ovf;
    logic [31:0] rdat;
    bit          m_full;
    bit          take;
    int          s;

    initial begin
      pv = 0; pd = '0; acc[0] = 0; acc[1] = 0; ovf = 0; rdat = '0;
    end

    always @(posedge clk) begin
      if (quiesce) begin
        q.delete();
        pv = 0; acc[0] = 0; acc[1] = 0; ovf = 0; rdat = '0;
      end else begin
        m_full = (q.size() + int'(pv)) >= 16;
        take   = wren && wopen && !m_full;
        if (wren && wopen && m_full) ovf = 1;
        if (rden && ropen && q.size() > 0) rdat = q.pop_front();
        if (pv) q.push_back(pd);
        pv = take;
        if (take) begin
          for (int l = 0; l < 2; l++) begin
            if (gm == 0) begin
              s = int'(wdata[16*l +: 16]);
            end else begin
              s = acc[l] + int'(wdata[16*l +: 16]);
`ifdef XILLY_LANE_SAT_EN
              if (s > 65535) s = 65535;
`else
              s = s % 65536;
`endif
              acc[l] = s;
            end
            pd[16*l +: 16] = 16'(s);
          end
        end
        if (!wopen) begin
          acc[0] = 0; acc[1] = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk("full", gm, {31'b0, full_w[gm]}, {31'b0, ((q.size() + int'(pv)) >= 16)});
        chk("empty", gm, {31'b0, empty_w[gm]}, {31'b0, (q.size() == 0)});
        chk("level", gm, {27'b0, lvl_w[gm]}, 32'(q.size()));
        chk("data", gm, rdat_w[gm], rdat);
        chk("overflow", gm, {31'b0, ovf_w[gm]}, {31'b0, ovf});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d);
    wdata = d; wren = 1'b1; step(); wren = 1'b0;
  endtask

  task automatic rd2(input string nm, input logic [31:0] e0, input logic [31:0] e1);
    rden = 1'b1; step(); rden = 1'b0;
    chk(nm, 0, rdat_w[0], e0);
    chk(nm, 1, rdat_w[1], e1);
    $display("read %s: mode0=%h mode1=%h", nm, rdat_w[0], rdat_w[1]);
  endtask

  task automatic rst();
    quiesce = 1'b1; step(); quiesce = 1'b0;
  endtask

  task automatic chk_idle_state(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_empty"}, m, {31'b0, empty_w[m]}, 32'd1);
      chk({nm, "_level"}, m, {27'b0, lvl_w[m]}, 32'd0);
      chk({nm, "_data"}, m, rdat_w[m], 32'd0);
      chk({nm, "_ovf"}, m, {31'b0, ovf_w[m]}, 32'd0);
      chk({nm, "_full"}, m, {31'b0, full_w[m]}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] e1;
    step(); step();
    quiesce = 1'b0;
    chk_en = 1'b1;
    chk_idle_state("reset");

    // Passthrough and running sum
    rst();
    wr(32'h0001_0000);
    chk("empty_k", 0, {31'b0, empty_w[0]}, 32'd1);
    wr(32'h0003_0002);
    chk("empty_k1", 0, {31'b0, empty_w[0]}, 32'd0);
    chk("empty_k1", 1, {31'b0, empty_w[1]}, 32'd0);
    wr(32'h0005_0004);
    step();
    rd2("sum0", 32'h0001_0000, 32'h0001_0000);
    rd2("sum1", 32'h0003_0002, 32'h0004_0002);
    rd2("sum2", 32'h0005_0004, 32'h0009_0006);

    // Wrap vs saturate
    rst();
    wr(32'h0000_FFF0);
    wr(32'h0000_0020);
    step();
    rd2("wrap0", 32'h0000_FFF0, 32'h0000_FFF0);
`ifdef XILLY_LANE_SAT_EN
    rd2("wrap1", 32'h0000_0020, 32'h0000_FFFF);
`else
    rd2("wrap1", 32'h0000_0020, 32'h0000_0010);
`endif

    // Full / overflow
    rst();
    for (int i = 0; i < 17; i++) begin
      wr(32'(i + 1));
      if (i == 15) begin
        chk("full16", 0, {31'b0, full_w[0]}, 32'd1);
        chk("full16", 1, {31'b0, full_w[1]}, 32'd1);
        chk("ovf16", 1, {31'b0, ovf_w[1]}, 32'd0);
      end
    end
    chk("ovf17", 0, {31'b0, ovf_w[0]}, 32'd1);
    chk("ovf17", 1, {31'b0, ovf_w[1]}, 32'd1);
    step();
    chk("lvl16", 0, {27'b0, lvl_w[0]}, 32'd16);
    chk("lvl16", 1, {27'b0, lvl_w[1]}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      e1 = 32'((i + 1) * (i + 2) / 2);
      rd2("fullrd", 32'(i + 1), e1);
    end
    chk("drained", 1, {31'b0, empty_w[1]}, 32'd1);

    // Stream end clears accumulators
    rst();
    wr(32'd5);
    wopen = 1'b0; step(); wopen = 1'b1;
    wr(32'd5);
    step();
    rd2("se0", 32'd5, 32'd5);
    rd2("se1", 32'd5, 32'd5);

    // Reset mid-operation
    rst();
    for (int i = 0; i < 8; i++) wr(32'(100 + i));
    step();
    rd2("pre", 32'd100, 32'd100);
    wr(32'd1); wr(32'd2); wr(32'd3); wr(32'd4); wr(32'd5); wr(32'd6); wr(32'd7); wr(32'd8); wr(32'd9);
    rst();
    chk_idle_state("midrst");
    wr(32'd7);
    step();
    rd2("post", 32'd7, 32'd7);

    // Randomised traffic, model-checked every cycle
    rst();
    for (int c = 0; c < 4000; c++) begin
      wren    = ($urandom % 3) != 0;
      rden    = ((c / 500) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      wopen   = ($urandom % 25) != 0;
      ropen   = ($urandom % 16) != 0;
      quiesce = ($urandom % 700) == 0;
      wdata   = (($urandom % 4) == 0) ? 32'hFFF0_FFF8 + $urandom % 32 : $urandom;
      step();
    end
    wren = 1'b0; rden = 1'b0; quiesce = 1'b0; wopen = 1'b1; ropen = 1'b1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
